// File: rtl/rriscv_pkg.sv
// ---------------------------------------------------------------------------
// rriscv_pkg
//
// Shared definitions for the rriscv core. This slice holds the pieces used by
// the program loader (instruction_encoder):
//   - XLEN                     : data / address width
//   - RV32 opcode, funct3 and funct7 constants for the supported subset
//   - mnemonic_e               : symbolic mnemonic code carried on the loader stream
//   - encoder_state_e          : loader FSM states
//   - IMM_*_MIN / IMM_*_MAX    : signed range limits for I/S/B/J immediates
//   - imm_in_range()           : signed range test used by the field packer
// ---------------------------------------------------------------------------
package rriscv_pkg;

    localparam int XLEN = 32;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // funct3 (inst[14:12])
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BNE  = 3'b001;

    // funct7 (inst[31:25]); MUL lives in the M-extension funct7 space
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    typedef enum logic [2:0] {
        MN_ADD  = 3'd0,
        MN_MUL  = 3'd1,
        MN_ADDI = 3'd2,
        MN_LW   = 3'd3,
        MN_SW   = 3'd4,
        MN_JAL  = 3'd5,
        MN_BNE  = 3'd6,
        MN_END  = 3'd7
    } mnemonic_e;

    typedef enum logic [2:0] {
        ENC_IDLE   = 3'd0,
        ENC_ACCEPT = 3'd1,
        ENC_WRITE  = 3'd2,
        ENC_DONE   = 3'd3,
        ENC_ERROR  = 3'd4
    } encoder_state_e;

    // Signed immediate limits: I/S hold 12 bits, B holds 13, J holds 21.
    localparam logic signed [XLEN-1:0] IMM_I_MIN = -32'sd2048;
    localparam logic signed [XLEN-1:0] IMM_I_MAX =  32'sd2047;
    localparam logic signed [XLEN-1:0] IMM_S_MIN = -32'sd2048;
    localparam logic signed [XLEN-1:0] IMM_S_MAX =  32'sd2047;
    localparam logic signed [XLEN-1:0] IMM_B_MIN = -32'sd4096;
    localparam logic signed [XLEN-1:0] IMM_B_MAX =  32'sd4095;
    localparam logic signed [XLEN-1:0] IMM_J_MIN = -32'sd1048576;
    localparam logic signed [XLEN-1:0] IMM_J_MAX =  32'sd1048575;

    // True when imm, read as two's complement, lies in [lo, hi].
    function automatic logic imm_in_range(input logic [XLEN-1:0]        imm,
                                          input logic signed [XLEN-1:0] lo,
                                          input logic signed [XLEN-1:0] hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/instruction_field_packer.sv
// ---------------------------------------------------------------------------
// instruction_field_packer
//
// Purely combinational RV32 packer for the loader subset. Places the register
// indices and immediate into the bit positions of the instruction format
// chosen by the mnemonic, and flags immediates that the format cannot hold.
//
// Ports:
//   mnemonic_i   in   3     mnemonic code (see mnemonic_e)
//   rd_i         in   5     destination register
//   rs1_i        in   5     source register 1
//   rs2_i        in   5     source register 2
//   imm_i        in   XLEN  signed byte immediate / offset
//   word_o       out  32    packed instruction word (0 for END)
//   range_err_o  out  1     immediate not representable in the format
// ---------------------------------------------------------------------------
module instruction_field_packer
    import rriscv_pkg::*;
(
    input  logic [2:0]      mnemonic_i,
    input  logic [4:0]      rd_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [31:0]     word_o,
    output logic            range_err_o
);

    mnemonic_e mnemonic;

    assign mnemonic = mnemonic_e'(mnemonic_i);

    // Fields a format does not use (rd on S/B, rs2 on I, ...) never reach the
    // word. B and J offsets are in halfwords, so bit 0 is dropped by the
    // packing and must be zero to be representable.
    always_comb begin
        word_o      = '0;
        range_err_o = 1'b0;
        case (mnemonic)
            MN_ADD: begin
                word_o = {F7_ADD, rs2_i, rs1_i, F3_ADD, rd_i, OPC_OP};
            end
            MN_MUL: begin
                word_o = {F7_MUL, rs2_i, rs1_i, F3_MUL, rd_i, OPC_OP};
            end
            MN_ADDI: begin
                word_o      = {imm_i[11:0], rs1_i, F3_ADDI, rd_i, OPC_OP_IMM};
                range_err_o = !imm_in_range(imm_i, IMM_I_MIN, IMM_I_MAX);
            end
            MN_LW: begin
                word_o      = {imm_i[11:0], rs1_i, F3_LW, rd_i, OPC_LOAD};
                range_err_o = !imm_in_range(imm_i, IMM_I_MIN, IMM_I_MAX);
            end
            MN_SW: begin
                word_o      = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OPC_STORE};
                range_err_o = !imm_in_range(imm_i, IMM_S_MIN, IMM_S_MAX);
            end
            MN_JAL: begin
                word_o      = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                               rd_i, OPC_JAL};
                range_err_o = !imm_in_range(imm_i, IMM_J_MIN, IMM_J_MAX) || imm_i[0];
            end
            MN_BNE: begin
                word_o      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BNE,
                               imm_i[4:1], imm_i[11], OPC_BRANCH};
                range_err_o = !imm_in_range(imm_i, IMM_B_MIN, IMM_B_MAX) || imm_i[0];
            end
            MN_END: begin
                word_o      = '0;
                range_err_o = 1'b0;
            end
            default: begin
                word_o      = '0;
                range_err_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
//
// Program loader for the rriscv core. Takes symbolic instructions over a
// valid/ready stream, packs each into an RV32 word and writes it to
// instruction memory at base, base+4, base+8, ... A program ends with the END
// mnemonic; an unrepresentable immediate or a full counter parks the loader
// in ERROR until the next start.
//
// Ports:
//   clk_i        in   1      clock
//   rst_i        in   1      synchronous active-high reset
//   start_i      in   1      begin a program (honoured in IDLE/DONE/ERROR)
//   base_addr_i  in   XLEN   first write address, latched on start
//   in_valid_i   in   1      instruction fields valid
//   in_ready_o   out  1      loader accepts fields (ACCEPT state)
//   mnemonic_i   in   3      mnemonic code (see rriscv_pkg::mnemonic_e)
//   rd_i         in   5      destination register
//   rs1_i        in   5      source register 1
//   rs2_i        in   5      source register 2
//   imm_i        in   XLEN   signed byte immediate / offset
//   mem_we_o     out  1      write request
//   mem_addr_o   out  XLEN   write address
//   mem_wdata_o  out  XLEN   encoded instruction word
//   mem_ready_i  in   1      memory takes the write this cycle
//   busy_o       out  1      not IDLE
//   done_o       out  1      one-cycle pulse after END is accepted
//   err_o        out  1      sticky error flag, cleared by start
//   count_o      out  CNT_W  instructions written since start
// ---------------------------------------------------------------------------
module instruction_encoder
    import rriscv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [XLEN-1:0]  base_addr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       mnemonic_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [XLEN-1:0]  imm_i,
    output logic             mem_we_o,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    input  logic             mem_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] count_o
);

    encoder_state_e   state_q, state_d;
    logic [XLEN-1:0]  base_q,  base_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  addr_q,  addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             err_q,   err_d;

    logic [31:0]      packed_word;
    logic             range_err;
    logic             is_end;
    logic             count_full;

    instruction_field_packer u_packer (
        .mnemonic_i  (mnemonic_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .imm_i       (imm_i),
        .word_o      (packed_word),
        .range_err_o (range_err)
    );

    assign is_end     = (mnemonic_e'(mnemonic_i) == MN_END);
    // The last counter value is reserved so count_o can never wrap to 0.
    assign count_full = (count_q == {CNT_W{1'b1}});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ENC_IDLE;
            base_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output logic. The address and word are captured at the
    // accepting handshake so they stay frozen for the whole WRITE, however
    // long the memory stalls. Address arithmetic wraps modulo 2^XLEN.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;

        in_ready_o  = 1'b0;
        mem_we_o    = 1'b0;
        done_o      = 1'b0;
        busy_o      = (state_q != ENC_IDLE);

        case (state_q)
            ENC_IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ENC_ACCEPT;
                end
            end

            ENC_ACCEPT: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (is_end) begin
                        state_d = ENC_DONE;
                    end else if (range_err || count_full) begin
                        err_d   = 1'b1;
                        state_d = ENC_ERROR;
                    end else begin
                        addr_d  = base_q + (XLEN'(count_q) << 2);
                        wdata_d = XLEN'(packed_word);
                        state_d = ENC_WRITE;
                    end
                end
            end

            ENC_WRITE: begin
                mem_we_o = 1'b1;
                if (mem_ready_i) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = ENC_ACCEPT;
                end
            end

            ENC_DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    base_d  = base_addr_i;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ENC_ACCEPT;
                end else begin
                    state_d = ENC_IDLE;
                end
            end

            ENC_ERROR: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ENC_ACCEPT;
                end
            end

            default: begin
                state_d = ENC_IDLE;
            end
        endcase
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign err_o       = err_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// ---------------------------------------------------------------------------
// tb_instruction_encoder
//
// Directed bench for the program loader. A reference model encodes each
// offered instruction with plain shift/mask arithmetic and queues the write it
// expects; a negedge monitor checks every memory write cycle against the head
// of that queue and decodes the word back into fields.
// ---------------------------------------------------------------------------
module tb_instruction_encoder;
    import rriscv_pkg::*;

    localparam int CNT_W = 16;

    logic             clk_i;
    logic             rst_i;
    logic             start_i;
    logic [31:0]      base_addr_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [2:0]       mnemonic_i;
    logic [4:0]       rd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [31:0]      imm_i;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic             mem_ready_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] count_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          mn;
        logic [31:0] rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    exp_t        mon_e;
    logic [31:0] model_base;
    int          model_idx;
    int          model_count;
    int          done_seen;
    int          total;
    int          bad;

    instruction_encoder #(.CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mnemonic_i  (mnemonic_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .imm_i       (imm_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .count_o     (count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Single comparison point: every check steps total and, on mismatch, bad.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference encoder: builds the word from the RV32 field layout with
    // shifts and masks, and decides legality from the signed value range.
    function automatic void model_encode(input int mn, input int rd, input int rs1,
                                         input int rs2, input int imm,
                                         output logic [31:0] w, output bit legal);
        logic [31:0] u, r_d, r_s1, r_s2;
        u     = imm;
        r_d   = rd;
        r_s1  = rs1;
        r_s2  = rs2;
        w     = 32'd0;
        legal = 1'b1;
        case (mn)
            0: w = (r_s2 << 20) | (r_s1 << 15) | (r_d << 7) | 32'h33;
            1: w = (32'd1 << 25) | (r_s2 << 20) | (r_s1 << 15) | (r_d << 7) | 32'h33;
            2: begin
                legal = (imm >= -2048) && (imm <= 2047);
                w = ((u & 32'hFFF) << 20) | (r_s1 << 15) | (r_d << 7) | 32'h13;
            end
            3: begin
                legal = (imm >= -2048) && (imm <= 2047);
                w = ((u & 32'hFFF) << 20) | (r_s1 << 15) | (32'd2 << 12) | (r_d << 7) | 32'h03;
            end
            4: begin
                legal = (imm >= -2048) && (imm <= 2047);
                w = (((u >> 5) & 32'h7F) << 25) | (r_s2 << 20) | (r_s1 << 15)
                  | (32'd2 << 12) | ((u & 32'h1F) << 7) | 32'h23;
            end
            5: begin
                legal = (imm >= -1048576) && (imm <= 1048575) && (imm % 2 == 0);
                w = (((u >> 20) & 32'd1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                  | (((u >> 11) & 32'd1) << 20) | (((u >> 12) & 32'hFF) << 12)
                  | (r_d << 7) | 32'h6F;
            end
            6: begin
                legal = (imm >= -4096) && (imm <= 4095) && (imm % 2 == 0);
                w = (((u >> 12) & 32'd1) << 31) | (((u >> 5) & 32'h3F) << 25)
                  | (r_s2 << 20) | (r_s1 << 15) | (32'd1 << 12)
                  | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'd1) << 7) | 32'h63;
            end
            default: begin
                w     = 32'd0;
                legal = 1'b1;
            end
        endcase
    endfunction

    // Decoder-side view of the immediate, as the core's decoder reassembles it.
    function automatic logic [31:0] decode_imm(input logic [31:0] w);
        logic [31:0] v;
        v = 32'd0;
        case (w[6:0])
            7'h13, 7'h03: v = {{20{w[31]}}, w[31:20]};
            7'h23:        v = {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63:        v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'h6F:        v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:      v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] log_data_at(input int i);
        return (i < wlog_data.size()) ? wlog_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_addr_at(input int i);
        return (i < wlog_addr.size()) ? wlog_addr[i] : 32'hDEAD_BEEF;
    endfunction

    // Monitor: every cycle the loader requests a write, the request must match
    // the oldest queued expectation; when memory takes it, the word is decoded
    // back and the expectation retired.
    always @(negedge clk_i) begin
        if (!rst_i && mem_we_o) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", {31'b0, mem_we_o}, 32'd0);
            end else begin
                mon_e = exp_q[0];
                checkOutput("write_addr", mem_addr_o, mon_e.addr);
                checkOutput("write_data", mem_wdata_o, mon_e.data);
                checkOutput("write_count", {16'b0, count_o}, 32'(model_count));
                checkOutput("ready_in_write", {31'b0, in_ready_o}, 32'd0);
                if (mem_ready_i) begin
                    if (mon_e.mn >= 2)
                        checkOutput("rt_imm", decode_imm(mem_wdata_o), mon_e.imm);
                    if (mon_e.mn != 5)
                        checkOutput("rt_rs1", {27'b0, mem_wdata_o[19:15]}, mon_e.rs1);
                    if (mon_e.mn <= 1 || mon_e.mn == 4 || mon_e.mn == 6)
                        checkOutput("rt_rs2", {27'b0, mem_wdata_o[24:20]}, mon_e.rs2);
                    if (mon_e.mn <= 3 || mon_e.mn == 5)
                        checkOutput("rt_rd", {27'b0, mem_wdata_o[11:7]}, mon_e.rd);
                    wlog_addr.push_back(mem_addr_o);
                    wlog_data.push_back(mem_wdata_o);
                    void'(exp_q.pop_front());
                    model_count++;
                end
            end
        end
        if (!rst_i && done_o)
            done_seen++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic doStart(input logic [31:0] base);
        start_i     = 1'b1;
        base_addr_i = base;
        model_base  = base;
        model_idx   = 0;
        model_count = 0;
        done_seen   = 0;
        exp_q.delete();
        wlog_addr.delete();
        wlog_data.delete();
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Offers one instruction, queues the write the model expects from it and
    // returns one step after the accepting edge.
    task automatic applyStimulus(input int mn, input int rd, input int rs1,
                                 input int rs2, input int imm);
        logic [31:0] w;
        bit          legal;
        bit          ok;
        int          cyc;
        exp_t        e;
        model_encode(mn, rd, rs1, rs2, imm, w, legal);
        if (mn != 7 && legal) begin
            e.addr = model_base + 32'(model_idx) * 32'd4;
            e.data = w;
            e.mn   = mn;
            e.rd   = 32'(rd);
            e.rs1  = 32'(rs1);
            e.rs2  = 32'(rs2);
            e.imm  = 32'(imm);
            exp_q.push_back(e);
            model_idx++;
        end
        mnemonic_i = 3'(mn);
        rd_i       = 5'(rd);
        rs1_i      = 5'(rs1);
        rs2_i      = 5'(rs2);
        imm_i      = 32'(imm);
        in_valid_i = 1'b1;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 50) begin
            @(negedge clk_i);
            if (in_ready_o) ok = 1'b1;
            cyc++;
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        checkOutput("handshake", {31'b0, ok}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] w;
        bit          legal;

        total       = 0;
        bad         = 0;
        model_base  = 32'd0;
        model_idx   = 0;
        model_count = 0;
        done_seen   = 0;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        base_addr_i = 32'd0;
        in_valid_i  = 1'b0;
        mnemonic_i  = 3'd0;
        rd_i        = 5'd0;
        rs1_i       = 5'd0;
        rs2_i       = 5'd0;
        imm_i       = 32'd0;
        mem_ready_i = 1'b1;

        // Pin the model to hand-encoded words before trusting it.
        model_encode(2, 1, 0, 0, 5, w, legal);    checkOutput("model_addi", w, 32'h0050_0093);
        model_encode(0, 3, 1, 2, 0, w, legal);    checkOutput("model_add", w, 32'h0020_81B3);
        model_encode(4, 0, 1, 2, 8, w, legal);    checkOutput("model_sw", w, 32'h0020_A423);
        model_encode(6, 0, 1, 2, -8, w, legal);   checkOutput("model_bne", w, 32'hFE20_9CE3);
        model_encode(5, 1, 0, 0, 16, w, legal);   checkOutput("model_jal", w, 32'h0100_00EF);
        model_encode(2, 1, 0, 0, 2048, w, legal); checkOutput("model_addi_range", {31'b0, legal}, 32'd0);
        model_encode(6, 0, 1, 2, 5, w, legal);    checkOutput("model_bne_odd", {31'b0, legal}, 32'd0);

        // Reset values
        waitCycles(2);
        checkOutput("rst_ready", {31'b0, in_ready_o}, 32'd0);
        checkOutput("rst_we", {31'b0, mem_we_o}, 32'd0);
        checkOutput("rst_done", {31'b0, done_o}, 32'd0);
        checkOutput("rst_err", {31'b0, err_o}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("rst_addr", mem_addr_o, 32'd0);
        checkOutput("rst_wdata", mem_wdata_o, 32'd0);
        checkOutput("rst_count", {16'b0, count_o}, 32'd0);
        rst_i = 1'b0;
        waitCycles(1);

        $display("[TB] basic stream at 0x100");
        doStart(32'h100);
        applyStimulus(2, 1, 0, 0, 5);
        applyStimulus(0, 3, 1, 2, 0);
        applyStimulus(7, 0, 0, 0, 0);
        waitCycles(3);
        checkOutput("t1_nwrites", 32'(wlog_data.size()), 32'd2);
        checkOutput("t1_data0", log_data_at(0), 32'h0050_0093);
        checkOutput("t1_addr0", log_addr_at(0), 32'h0000_0100);
        checkOutput("t1_data1", log_data_at(1), 32'h0020_81B3);
        checkOutput("t1_addr1", log_addr_at(1), 32'h0000_0104);
        checkOutput("t1_done_pulses", 32'(done_seen), 32'd1);
        checkOutput("t1_count", {16'b0, count_o}, 32'd2);
        checkOutput("t1_idle", {31'b0, busy_o}, 32'd0);

        $display("[TB] store with memory stalled three cycles");
        doStart(32'h400);
        mem_ready_i = 1'b0;
        applyStimulus(4, 7, 1, 2, 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("t2_we_hold", {31'b0, mem_we_o}, 32'd1);
            checkOutput("t2_addr_hold", mem_addr_o, 32'h0000_0400);
            checkOutput("t2_data_hold", mem_wdata_o, 32'h0020_A423);
            checkOutput("t2_ready_low", {31'b0, in_ready_o}, 32'd0);
        end
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b1;
        applyStimulus(7, 0, 0, 0, 0);
        checkOutput("t2_nwrites", 32'(wlog_data.size()), 32'd1);
        checkOutput("t2_data0", log_data_at(0), 32'h0020_A423);
        checkOutput("t2_count", {16'b0, count_o}, 32'd1);

        // Started straight from DONE: the previous program's pulse is still
        // observed after this start, so two pulses are expected in total.
        $display("[TB] branch and jump, started from DONE");
        doStart(32'h300);
        checkOutput("t3_start_from_done", {31'b0, in_ready_o}, 32'd1);
        applyStimulus(6, 9, 1, 2, -8);
        applyStimulus(5, 1, 0, 0, 16);
        applyStimulus(7, 0, 0, 0, 0);
        waitCycles(3);
        checkOutput("t3_data0", log_data_at(0), 32'hFE20_9CE3);
        checkOutput("t3_addr0", log_addr_at(0), 32'h0000_0300);
        checkOutput("t3_data1", log_data_at(1), 32'h0100_00EF);
        checkOutput("t3_addr1", log_addr_at(1), 32'h0000_0304);
        checkOutput("t3_done_pulses", 32'(done_seen), 32'd2);

        $display("[TB] immediate range errors and recovery");
        doStart(32'h500);
        applyStimulus(2, 1, 0, 0, 2048);
        checkOutput("t4_err", {31'b0, err_o}, 32'd1);
        checkOutput("t4_ready", {31'b0, in_ready_o}, 32'd0);
        checkOutput("t4_we", {31'b0, mem_we_o}, 32'd0);
        waitCycles(3);
        checkOutput("t4_err_sticky", {31'b0, err_o}, 32'd1);
        checkOutput("t4_busy", {31'b0, busy_o}, 32'd1);
        checkOutput("t4_nwrites", 32'(wlog_data.size()), 32'd0);
        doStart(32'h500);
        checkOutput("t4_err_cleared", {31'b0, err_o}, 32'd0);
        applyStimulus(6, 0, 1, 2, 6);
        applyStimulus(6, 0, 1, 2, 5);
        checkOutput("t4_bne_odd_err", {31'b0, err_o}, 32'd1);
        checkOutput("t4_count_after_err", {16'b0, count_o}, 32'd1);
        waitCycles(2);
        checkOutput("t4_nwrites_bne", 32'(wlog_data.size()), 32'd1);
        doStart(32'h600);
        checkOutput("t4_err_cleared2", {31'b0, err_o}, 32'd0);
        applyStimulus(2, 2, 0, 0, -2048);
        applyStimulus(3, 3, 2, 0, 4);
        applyStimulus(1, 4, 2, 3, 0);
        applyStimulus(2, 5, 0, 0, 2047);
        applyStimulus(7, 0, 0, 0, 0);
        waitCycles(3);
        checkOutput("t4_stream_count", {16'b0, count_o}, 32'd4);
        checkOutput("t4_stream_err", {31'b0, err_o}, 32'd0);
        checkOutput("t4_addr3", log_addr_at(3), 32'h0000_060C);

        $display("[TB] address wrap");
        doStart(32'hFFFF_FFFC);
        applyStimulus(2, 1, 0, 0, 1);
        applyStimulus(2, 2, 0, 0, 2);
        applyStimulus(7, 0, 0, 0, 0);
        waitCycles(3);
        checkOutput("t5_addr0", log_addr_at(0), 32'hFFFF_FFFC);
        checkOutput("t5_addr1", log_addr_at(1), 32'h0000_0000);
        checkOutput("t5_err", {31'b0, err_o}, 32'd0);
        checkOutput("t5_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset during write");
        doStart(32'h200);
        mem_ready_i = 1'b0;
        applyStimulus(0, 1, 2, 3, 0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        exp_q.delete();
        checkOutput("t6_we", {31'b0, mem_we_o}, 32'd0);
        checkOutput("t6_count", {16'b0, count_o}, 32'd0);
        checkOutput("t6_busy", {31'b0, busy_o}, 32'd0);
        waitCycles(3);
        checkOutput("t6_still_idle", {31'b0, busy_o}, 32'd0);
        checkOutput("t6_no_ready", {31'b0, in_ready_o}, 32'd0);
        checkOutput("t6_no_we", {31'b0, mem_we_o}, 32'd0);
        checkOutput("t6_nwrites", 32'(wlog_data.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
